// File: rtl/stopwatch_counter_pkg.sv
// Shared definitions for the stopwatch: control states, BCD field limits
// and the preset clamp helper used when loading digits.
// Pure declarations; no logic of its own.
package stopwatch_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Largest value a units digit (sec_ones, min_ones) may hold.
  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  // Largest value the seconds-tens digit may hold.
  localparam logic [3:0] BCD_MAX_TENS = 4'd5;

  // Saturate a preset digit to its field maximum.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit that counts up or down by one when stepped, wrapping at MAX.
// Latency: value updates on the clock edge after step; carry is combinational.
// Backpressure: none; clear beats load beats step.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       step,
  input  logic       down,
  output logic [3:0] value,
  output logic       carry
);

  // Carry (up) or borrow (down) leaves this digit when a step crosses its limit.
  assign carry = step & (down ? (value == 4'd0) : (value == MAX));

  // Digit register: clear, load, then single-step increment/decrement with wrap.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      value <= 4'd0;
    end else if (clear) begin
      value <= 4'd0;
    end else if (load) begin
      value <= load_val;
    end else if (step) begin
      if (down) begin
        value <= (value == 4'd0) ? MAX : value - 4'd1;
      end else begin
        value <= (value == MAX) ? 4'd0 : value + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with run/pause/done control, up or down counting.
// Latency: a tick rising edge updates digits one clock later; outputs registered.
// Backpressure: none; clear > load > start > count, losers are dropped.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int MAX_MIN_TENS = 5
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        tick,
  input  logic        start,
  input  logic        clear,
  input  logic        load,
  input  logic        dir,
  input  logic [15:0] preset,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        wrap
);

  localparam logic [3:0] MIN_TENS_MAX = 4'(MAX_MIN_TENS);

  state_t      state_q;
  state_t      state_d;
  logic        dir_q;
  logic        dir_d;
  logic        tick_q;
  logic        tick_edge;
  logic        count_en;
  logic [15:0] load_val;
  logic [3:0]  carry;
  logic [3:0]  sec_ones;
  logic [3:0]  sec_tens;
  logic [3:0]  min_ones;
  logic [3:0]  min_tens;

  assign tick_edge = tick & ~tick_q;
  assign digits    = {min_tens, min_ones, sec_tens, sec_ones};
  assign running   = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

  // Out-of-range preset digits saturate to the field maximum.
  assign load_val = {clamp_digit(preset[15:12], MIN_TENS_MAX),
                     clamp_digit(preset[11:8],  BCD_MAX_ONES),
                     clamp_digit(preset[7:4],   BCD_MAX_TENS),
                     clamp_digit(preset[3:0],   BCD_MAX_ONES)};

  // Next state, direction latch and count enable, resolved in priority order.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    count_en = 1'b0;
    if (clear || load) begin
      state_d = ST_IDLE;
    end else if (start) begin
      unique case (state_q)
        ST_IDLE: begin
          dir_d   = dir;
          // Counting down from zero has nowhere to go.
          state_d = (dir && digits == 16'h0000) ? ST_DONE : ST_RUN;
        end
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: begin
          dir_d   = dir;
          state_d = ST_RUN;
        end
        default:  state_d = state_q;
      endcase
    end else if (state_q == ST_RUN && tick_edge) begin
      count_en = 1'b1;
      // Down-count reaching 00:00 finishes in the same cycle.
      if (dir_q && digits == 16'h0001) begin
        state_d = ST_DONE;
      end
    end
  end

  // Control registers; tick history tracks the input in every state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      tick_q  <= 1'b1;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tick_q  <= tick;
      wrap    <= count_en & ~dir_q & carry[3];
    end
  end

  bcd_digit #(.MAX(BCD_MAX_ONES)) u_sec_ones (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (clear),
    .load     (load),
    .load_val (load_val[3:0]),
    .step     (count_en),
    .down     (dir_q),
    .value    (sec_ones),
    .carry    (carry[0])
  );

  bcd_digit #(.MAX(BCD_MAX_TENS)) u_sec_tens (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (clear),
    .load     (load),
    .load_val (load_val[7:4]),
    .step     (carry[0]),
    .down     (dir_q),
    .value    (sec_tens),
    .carry    (carry[1])
  );

  bcd_digit #(.MAX(BCD_MAX_ONES)) u_min_ones (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (clear),
    .load     (load),
    .load_val (load_val[11:8]),
    .step     (carry[1]),
    .down     (dir_q),
    .value    (min_ones),
    .carry    (carry[2])
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (clear),
    .load     (load),
    .load_val (load_val[15:12]),
    .step     (carry[2]),
    .down     (dir_q),
    .value    (min_tens),
    .carry    (carry[3])
  );

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with a seconds-based reference model.
// Model updates on the rising edge; outputs are compared on every falling edge.
// Inputs are driven on falling edges, one cycle per step call.
module tb_stopwatch_counter;

  localparam int MAXT   = 5;
  localparam int PERIOD = (MAXT + 1) * 10 * 60;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] preset = 16'h0000;
  logic [15:0] digits;
  logic        running;
  logic        done;
  logic        wrap;

  int errors = 0;
  int checks = 0;
  int wrap_seen = 0;
  bit chk_en = 1'b0;

  // Model: elapsed seconds and control state (0 idle, 1 run, 2 pause, 3 done).
  int m_t = 0;
  int m_state = 0;
  bit m_dir = 1'b0;
  bit m_tq = 1'b1;
  bit m_wrap = 1'b0;

  stopwatch_counter #(.MAX_MIN_TENS(MAXT)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .tick    (tick),
    .start   (start),
    .clear   (clear),
    .load    (load),
    .dir     (dir),
    .preset  (preset),
    .digits  (digits),
    .running (running),
    .done    (done),
    .wrap    (wrap)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] to_bcd(input int t);
    int m;
    int s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int lim(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int preset_secs(input logic [15:0] p);
    int mt;
    int mo;
    int st;
    int so;
    mt = lim(int'(p[15:12]), MAXT);
    mo = lim(int'(p[11:8]), 9);
    st = lim(int'(p[7:4]), 5);
    so = lim(int'(p[3:0]), 9);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the stopwatch rules, in whole seconds.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_t = 0; m_state = 0; m_dir = 1'b0; m_tq = 1'b1; m_wrap = 1'b0;
    end else begin
      bit ev;
      ev = tick && !m_tq && m_state == 1;
      m_tq = tick;
      m_wrap = 1'b0;
      if (clear) begin
        m_t = 0; m_state = 0;
      end else if (load) begin
        m_t = preset_secs(preset); m_state = 0;
      end else if (start) begin
        if (m_state == 0) begin
          m_dir = dir;
          m_state = (dir && m_t == 0) ? 3 : 1;
        end else if (m_state == 1) begin
          m_state = 2;
        end else if (m_state == 2) begin
          m_dir = dir; m_state = 1;
        end
      end else if (ev) begin
        if (!m_dir) begin
          if (m_t == PERIOD - 1) begin m_t = 0; m_wrap = 1'b1; end
          else m_t = m_t + 1;
        end else begin
          m_t = (m_t == 0) ? PERIOD - 1 : m_t - 1;
          if (m_t == 0) m_state = 3;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_digits", digits, to_bcd(m_t));
      chk("model_running", 16'(running), 16'(m_state == 1));
      chk("model_done", 16'(done), 16'(m_state == 3));
      chk("model_wrap", 16'(wrap), 16'(m_wrap));
      if (wrap) wrap_seen++;
    end
  end

  task automatic step(input logic t, input logic s, input logic c, input logic l,
                      input logic d, input logic [15:0] p);
    tick = t; start = s; clear = c; load = l; dir = d; preset = p;
    @(negedge clock);
  endtask

  initial begin
    chk_en = 1'b1;
    @(negedge clock);
    chk("reset_digits", digits, 16'h0000);
    chk("reset_running", 16'(running), 16'h0);
    chk("reset_done", 16'(done), 16'h0);
    chk("reset_wrap", 16'(wrap), 16'h0);
    resetn = 1'b1;

    // Up-count 61 seconds from zero.
    step(0, 1, 0, 0, 0, 16'h0);
    chk("start_up_running", 16'(running), 16'h1);
    for (int i = 0; i < 61; i++) begin
      step(1, 0, 0, 0, 0, 16'h0);
      step(0, 0, 0, 0, 0, 16'h0);
    end
    chk("count61_digits", digits, 16'h0101);
    chk("count61_running", 16'(running), 16'h1);
    chk("count61_nowrap", 16'(wrap_seen), 16'h0);

    // Wrap at 59:59.
    step(0, 0, 0, 1, 0, 16'h5958);
    chk("load5958_digits", digits, 16'h5958);
    chk("load5958_idle", 16'(running), 16'h0);
    step(0, 1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    chk("up_5959", digits, 16'h5959);
    step(0, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    chk("wrap_digits", digits, 16'h0000);
    chk("wrap_high", 16'(wrap), 16'h1);
    step(0, 0, 0, 0, 0, 16'h0);
    chk("wrap_one_cycle", 16'(wrap), 16'h0);
    chk("wrap_seen_once", 16'(wrap_seen), 16'h1);

    // Down-count to done; extra tick and start ignored.
    step(0, 0, 0, 1, 0, 16'h0002);
    step(0, 1, 0, 0, 1, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    chk("down_0001", digits, 16'h0001);
    step(0, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    chk("down_0000", digits, 16'h0000);
    chk("down_done", 16'(done), 16'h1);
    chk("down_not_running", 16'(running), 16'h0);
    step(0, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 1, 16'h0);
    chk("done_hold_digits", digits, 16'h0000);
    chk("done_ignores_start", 16'(done), 16'h1);

    // Held tick counts once; pause freezes; resume continues.
    step(0, 0, 1, 0, 0, 16'h0);
    chk("clear_from_done", 16'(done), 16'h0);
    step(0, 1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 16'h0);
    chk("held_tick_once", digits, 16'h0001);
    step(0, 0, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 0, 16'h0);
    chk("paused", 16'(running), 16'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 16'h0);
      step(0, 0, 0, 0, 0, 16'h0);
    end
    chk("pause_frozen", digits, 16'h0001);
    step(0, 1, 0, 0, 0, 16'h0);
    chk("resumed", 16'(running), 16'h1);
    step(1, 0, 0, 0, 0, 16'h0);
    chk("resume_counts", digits, 16'h0002);

    // Clear beats load beats tick; clamped load; load beats start.
    step(0, 0, 0, 0, 0, 16'h0);
    step(1, 0, 1, 1, 0, 16'h1234);
    chk("clr_load_tick_digits", digits, 16'h0000);
    chk("clr_load_tick_idle", 16'(running), 16'h0);
    step(0, 0, 0, 1, 0, 16'hFA7F);
    chk("clamp_load", digits, 16'h5959);
    step(0, 1, 0, 1, 0, 16'h0100);
    chk("load_over_start_digits", digits, 16'h0100);
    chk("load_over_start_idle", 16'(running), 16'h0);
    step(0, 0, 1, 0, 0, 16'h0);
    step(0, 1, 0, 0, 1, 16'h0);
    chk("down_start_at_zero_done", 16'(done), 16'h1);
    step(0, 0, 0, 1, 0, 16'h0);
    chk("load_leaves_done", 16'(done), 16'h0);

    // Asynchronous reset mid-run with tick held high through release.
    step(0, 0, 0, 1, 0, 16'h0029);
    step(0, 1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    chk("pre_reset_0030", digits, 16'h0030);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_digits", digits, 16'h0000);
    chk("async_reset_running", 16'(running), 16'h0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    step(1, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    chk("post_reset_idle", 16'(running), 16'h0);
    chk("post_reset_digits", digits, 16'h0000);
    step(1, 1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    chk("held_tick_no_count", digits, 16'h0000);
    chk("post_reset_run", 16'(running), 16'h1);
    step(0, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    chk("post_reset_counts", digits, 16'h0001);
    chk("total_wraps", 16'(wrap_seen), 16'h1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter MAX_MIN_TENS, default 5, highest minutes-tens digit; up-count wraps after MAX_MIN_TENS9:59.
REQ-002 CLOCK  input  1  system clock; all logic on its rising edge.
REQ-003 RESETN  input  1  asynchronous, active-low reset.
REQ-004 TICK  input  1  one-second tick pulse from the upstream rate divider, CLOCK domain; may stay high for more than one cycle.
REQ-005 START  input  1  pulse; toggles run/pause.
REQ-006 CLEAR  input  1  pulse; zeroes all digits and enters IDLE.
REQ-007 LOAD  input  1  pulse; loads the preset digits.
REQ-008 DIR  input  1  0 = count up, 1 = count down; sampled only on the START edge that leaves IDLE or PAUSE.
REQ-009 PRESET  input  16  BCD preset {min_tens, min_ones, sec_tens, sec_ones}.
REQ-010 DIGITS  output  16  BCD count {min_tens, min_ones, sec_tens, sec_ones}, registered.
REQ-011 RUNNING  output  1  high in RUN.
REQ-012 DONE  output  1  high in state DONE.
REQ-013 WRAP  output  1  one-cycle pulse on up-count wrap to 00:00.

Function
REQ-014 A count event SHALL occur only on a TICK rising edge: TICK=1 in cycle N and TICK=0 in cycle N-1, in RUN. Each event updates DIGITS at the end of cycle N.
REQ-015 Up-count: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens; MAX_MIN_TENS9:59 -> 00:00 with WRAP high for that one cycle.
REQ-016 Down-count: borrows mirror REQ-015. The event that reaches 00:00 SHALL enter DONE in the same cycle.
REQ-017 States: IDLE, RUN, PAUSE, DONE.
REQ-018 IDLE: START -> RUN and latch DIR. If DIR=1 and DIGITS=00:00, START -> DONE instead.
REQ-019 RUN: START -> PAUSE; count events as defined in REQ-014 to REQ-016.
REQ-020 PAUSE: START -> RUN and re-latch DIR; TICK ignored.
REQ-021 DONE: DIGITS hold at 00:00; START ignored; CLEAR or LOAD -> IDLE.
REQ-022 LOAD in any state SHALL copy PRESET into DIGITS and go to IDLE. Any digit above 9, or a sec_tens above 5, or a min_tens above MAX_MIN_TENS, SHALL be clamped to that field's maximum.
REQ-023 Priority within one cycle: CLEAR > LOAD > START > count event. A lower-priority event in the same cycle SHALL be discarded, not deferred.
REQ-024 A TICK edge in the same cycle as the START that enters RUN SHALL NOT count.
REQ-025 The TICK edge detector SHALL keep updating in every state, so a TICK held high across a pause does not count on resume.
REQ-026 Digit arithmetic SHALL stay within 4-bit BCD fields; no binary intermediate wider than 4 bits per digit.

Reset
REQ-027 RESETN low SHALL immediately force: DIGITS=0, state=IDLE, RUNNING=0, DONE=0, WRAP=0, latched DIR=0, TICK history=1 (a TICK high at release does not count).
REQ-028 Reset asserted mid-RUN SHALL abandon the count with no WRAP or DONE pulse.

Structure
REQ-029 The state encoding and the BCD field limits (9, 5) SHALL live in the shared com package.
REQ-030 One sub-module, bcd_digit: a single up/down BCD digit with parameterised maximum, carry/borrow in and out; instantiated four times.

Verification
REQ-031 Reset, START with DIR=0, then 61 single-cycle TICKs -> DIGITS=0x0101, RUNNING=1, WRAP never high.
REQ-032 LOAD 0x5958, START with DIR=0, then 2 TICKs -> DIGITS 0x5959, then 0x0000 with WRAP high for exactly one cycle.
REQ-033 LOAD 0x0002, START with DIR=1, then 3 TICKs -> DIGITS 0x0001, then 0x0000 with DONE=1, third TICK ignored, START ignored.
REQ-034 TICK held high 5 cycles in RUN -> exactly one increment; START pause, TICK pulses -> DIGITS frozen; START resume -> counting continues.
REQ-035 CLEAR, LOAD and TICK in the same cycle -> DIGITS=0, IDLE. LOAD 0xFA7F -> DIGITS=0x5959.
REQ-036 RESETN pulsed low mid-RUN at 0x0030 -> outputs zero asynchronously, IDLE after release, no count from a TICK held high at release.
